// File: rtl/pyramid_pkg.sv
// -----------------------------------------------------------------------------
// pyramid_pkg
// Shared constants and types for the Gaussian-pyramid dump sequencer.
//   NUM_OCTAVES / NUM_LEVELS : pyramid geometry (3 x 3 = 9 BRAM banks)
//   HDR_MAGIC                : upper nibble of the per-image header byte
//   dump_state_t             : sequencer FSM states
//   bank_index()             : octave/level -> bank number (octave*3 + level)
// -----------------------------------------------------------------------------
package pyramid_pkg;

  localparam int         NUM_OCTAVES = 3;
  localparam int         NUM_LEVELS  = 3;
  localparam int         NUM_BANKS   = NUM_OCTAVES * NUM_LEVELS;
  localparam logic [3:0] HDR_MAGIC   = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_ISSUE,
    ST_WAIT1,
    ST_WAIT2,
    ST_SEND,
    ST_DONE
  } dump_state_t;

  function automatic logic [3:0] bank_index(input logic [1:0] octave,
                                            input logic [1:0] level);
    return 4'(octave) * 4'd3 + 4'(level);
  endfunction

endpackage

// File: rtl/pyramid_dump_ctrl_if.sv
// -----------------------------------------------------------------------------
// pyramid_dump_ctrl_if
// Bundles the BRAM read bus and the byte stream towards the UART sender.
//   read_addr_out  : shared read address to all nine banks
//   read_en_out    : one-hot bank read enable (bit = octave*3 + level)
//   bank_pixel_in  : flattened bank outputs, bank k at [k*BIT_DEPTH +: BIT_DEPTH]
//   tx_data_out    : byte to UART sender
//   tx_valid_out   : byte valid
//   tx_ready_in    : sender accepts byte when valid & ready at a rising edge
// master = the dump sequencer, slave = the BRAM/UART side.
// -----------------------------------------------------------------------------
interface pyramid_dump_ctrl_if #(
  parameter int BIT_DEPTH = 8,
  parameter int ADDR_W    = 12
);
  import pyramid_pkg::*;

  logic [ADDR_W-1:0]              read_addr_out;
  logic [NUM_BANKS-1:0]           read_en_out;
  logic [NUM_BANKS*BIT_DEPTH-1:0] bank_pixel_in;
  logic [7:0]                     tx_data_out;
  logic                           tx_valid_out;
  logic                           tx_ready_in;

  modport master (
    output read_addr_out, read_en_out, tx_data_out, tx_valid_out,
    input  bank_pixel_in, tx_ready_in
  );

  modport slave (
    input  read_addr_out, read_en_out, tx_data_out, tx_valid_out,
    output bank_pixel_in, tx_ready_in
  );

endinterface

// File: rtl/pyramid_scan_counter.sv
// -----------------------------------------------------------------------------
// pyramid_scan_counter
// Octave / level / pixel-address counters for the pyramid dump.
//   clk_in, rst_in   : clock, synchronous active-high reset
//   clear_in         : restart at octave 0, level 0, addr 0
//   advance_in       : step to the next pixel (wraps through levels/octaves)
//   octave_out       : current octave (0..2)
//   level_out        : current level (0..2)
//   addr_out         : current pixel address within the image
//   last_pixel_out   : addr is the final pixel of the current image
//   last_image_out   : current image is octave 2, level 2
// -----------------------------------------------------------------------------
module pyramid_scan_counter
  import pyramid_pkg::*;
#(
  parameter int TOP_WIDTH  = 64,
  parameter int TOP_HEIGHT = 64,
  parameter int ADDR_W     = $clog2(TOP_WIDTH * TOP_HEIGHT)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clear_in,
  input  logic              advance_in,
  output logic [1:0]        octave_out,
  output logic [1:0]        level_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              last_pixel_out,
  output logic              last_image_out
);

  // Each octave halves both dimensions, so the image shrinks by 4x.
  localparam int SIZE0 = TOP_WIDTH * TOP_HEIGHT;
  localparam int SIZE1 = (TOP_WIDTH >> 1) * (TOP_HEIGHT >> 1);
  localparam int SIZE2 = (TOP_WIDTH >> 2) * (TOP_HEIGHT >> 2);
  localparam logic [ADDR_W-1:0] LAST0 = ADDR_W'(SIZE0 - 1);
  localparam logic [ADDR_W-1:0] LAST1 = ADDR_W'(SIZE1 - 1);
  localparam logic [ADDR_W-1:0] LAST2 = ADDR_W'(SIZE2 - 1);

  logic [1:0]        octave_q, octave_d;
  logic [1:0]        level_q, level_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    last_addr = LAST0;
    case (octave_q)
      2'd1:    last_addr = LAST1;
      2'd2:    last_addr = LAST2;
      default: last_addr = LAST0;
    endcase
  end

  assign last_pixel_out = (addr_q == last_addr);
  assign last_image_out = (octave_q == 2'(NUM_OCTAVES - 1)) &&
                          (level_q  == 2'(NUM_LEVELS - 1));

  always_comb begin
    octave_d = octave_q;
    level_d  = level_q;
    addr_d   = addr_q;
    if (clear_in) begin
      octave_d = '0;
      level_d  = '0;
      addr_d   = '0;
    end else if (advance_in) begin
      if (!last_pixel_out) begin
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        addr_d = '0;
        if (level_q != 2'(NUM_LEVELS - 1)) begin
          level_d = level_q + 2'd1;
        end else begin
          level_d = '0;
          // Wrap to octave 0 after the final image so a later dump starts clean.
          octave_d = last_image_out ? 2'd0 : octave_q + 2'd1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      octave_q <= '0;
      level_q  <= '0;
      addr_q   <= '0;
    end else begin
      octave_q <= octave_d;
      level_q  <= level_d;
      addr_q   <= addr_d;
    end
  end

  assign octave_out = octave_q;
  assign level_out  = level_q;
  assign addr_out   = addr_q;

endmodule

// File: rtl/pyramid_dump_ctrl.sv
// -----------------------------------------------------------------------------
// pyramid_dump_ctrl
// Reads all nine pyramid BRAMs (octave-major, then level, then address) and
// streams the top 8 bits of each pixel as bytes to the UART sender.
//   clk_in    : clock
//   rst_in    : synchronous active-high reset; aborts a dump without done
//   start_in  : single-cycle pulse, starts a dump when idle
//   bus       : pyramid_dump_ctrl_if.master (BRAM read bus + byte stream)
//   busy_out  : high while a dump is in progress
//   done_out  : one-cycle pulse after the final byte is accepted
// Build option: define PYRAMID_DUMP_HEADER_EN to emit a header byte
// {4'hA, octave, level} before each image.
// -----------------------------------------------------------------------------
module pyramid_dump_ctrl
  import pyramid_pkg::*;
#(
  parameter int BIT_DEPTH  = 8,
  parameter int TOP_WIDTH  = 64,
  parameter int TOP_HEIGHT = 64,
  parameter int ADDR_W     = $clog2(TOP_WIDTH * TOP_HEIGHT)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  pyramid_dump_ctrl_if.master  bus,
  output logic                 busy_out,
  output logic                 done_out
);

`ifdef PYRAMID_DUMP_HEADER_EN
  localparam dump_state_t IMAGE_ENTRY = ST_HEADER;
`else
  localparam dump_state_t IMAGE_ENTRY = ST_ISSUE;
`endif

  dump_state_t       state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              scan_clear, scan_advance;
  logic [1:0]        octave, level;
  logic [ADDR_W-1:0] addr;
  logic              last_pixel, last_image;
  logic [3:0]        bank_sel;
  logic [7:0]        bank_byte;

  pyramid_scan_counter #(
    .TOP_WIDTH  (TOP_WIDTH),
    .TOP_HEIGHT (TOP_HEIGHT),
    .ADDR_W     (ADDR_W)
  ) u_scan (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .clear_in       (scan_clear),
    .advance_in     (scan_advance),
    .octave_out     (octave),
    .level_out      (level),
    .addr_out       (addr),
    .last_pixel_out (last_pixel),
    .last_image_out (last_image)
  );

  assign bank_sel           = bank_index(octave, level);
  assign bus.read_addr_out  = addr;

  // Constant-index mux keeps the byte select free of variable part-selects.
  always_comb begin
    bank_byte = 8'h00;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (bank_sel == 4'(k)) begin
        bank_byte = bus.bank_pixel_in[k*BIT_DEPTH + BIT_DEPTH - 8 +: 8];
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    tx_data_d        = tx_data_q;
    scan_clear       = 1'b0;
    scan_advance     = 1'b0;
    bus.read_en_out  = '0;
    bus.tx_valid_out = 1'b0;
    bus.tx_data_out  = tx_data_q;
    busy_out         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done_out         = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          scan_clear = 1'b1;
          state_d    = IMAGE_ENTRY;
        end
      end
`ifdef PYRAMID_DUMP_HEADER_EN
      ST_HEADER: begin
        bus.tx_valid_out = 1'b1;
        bus.tx_data_out  = {HDR_MAGIC, octave, level};
        if (bus.tx_ready_in) state_d = ST_ISSUE;
      end
`endif
      ST_ISSUE: begin
        bus.read_en_out = NUM_BANKS'(1) << bank_sel;
        state_d         = ST_WAIT1;
      end
      ST_WAIT1: state_d = ST_WAIT2;
      ST_WAIT2: begin
        // Bank data for the ISSUE cycle arrives two cycles later, i.e. now.
        tx_data_d = bank_byte;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        bus.tx_valid_out = 1'b1;
        if (bus.tx_ready_in) begin
          scan_advance = 1'b1;
          if (last_pixel && last_image) state_d = ST_DONE;
          else if (last_pixel)          state_d = IMAGE_ENTRY;
          else                          state_d = ST_ISSUE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule

// File: doc/pyramid_dump_ctrl.md
# pyramid_dump_ctrl

Sequencer that reads back all nine Gaussian-pyramid BRAMs (3 octaves × 3 levels) in a fixed order and streams their pixels as bytes to the UART transmit path. It sits between the pyramid BRAM read ports (port B) and the byte-level UART sender, owning the shared read address and the per-bank read enables. It replaces ad-hoc per-bank readout in top level: one `start_in` pulse dumps the whole pyramid.

## Interface
- `BIT_DEPTH`, 8: pixel width; must be ≥ 8; transmitted byte is `pixel[BIT_DEPTH-1 -: 8]`.
- `TOP_WIDTH`, 64: octave-1 image width; power of two.
- `TOP_HEIGHT`, 64: octave-1 image height; power of two.
- `ADDR_W`, `$clog2(TOP_WIDTH*TOP_HEIGHT)`: shared read address width.

- `clk_in` in 1: single clock; all logic on its rising edge.
- `rst_in` in 1: synchronous, active-high reset.
- `start_in` in 1: single-cycle pulse; begins a dump when idle.
- `read_addr_out` out `ADDR_W`: shared read address to all nine banks.
- `read_en_out` out 9: one-hot bank read enable; bit index = octave×3 + level (octave, level 0-based).
- `bank_pixel_in` in 9×`BIT_DEPTH`: flattened bank outputs; bank k at `[k*BIT_DEPTH +: BIT_DEPTH]`.
- `tx_data_out` out 8: byte to UART sender.
- `tx_valid_out` out 1: byte valid.
- `tx_ready_in` in 1: sender accepts byte on an edge where valid & ready.
- `busy_out` out 1: high from the cycle after accepted start until dump completes.
- `done_out` out 1: one-cycle pulse after the final byte is accepted.

## Operation
- States: IDLE, HEADER, ISSUE, WAIT1, WAIT2, SEND, DONE.
- IDLE: `start_in` high → HEADER (if header enabled) else ISSUE; octave=level=addr=0. `start_in` ignored in every other state.
- HEADER: `tx_valid_out`=1, `tx_data_out`={4'hA, octave[1:0], level[1:0]}; on handshake → ISSUE.
- ISSUE: `read_en_out` one-hot for current bank for exactly this cycle, `read_addr_out`=addr → WAIT1 → WAIT2.
- WAIT2: capture selected bank slice at end of cycle into `tx_data_out` → SEND.
- SEND: `tx_valid_out`=1, data stable until handshake. On handshake:
  - addr < size(octave)−1: addr+1 → ISSUE.
  - else addr=0; level<2: level+1; else level=0, octave+1; next image → HEADER/ISSUE.
  - last pixel of octave 2 level 2 → DONE.
- size(o) = (TOP_WIDTH>>o)·(TOP_HEIGHT>>o); 64×64 gives 4096/1024/256.
- DONE: `done_out`=1 one cycle, `busy_out`=0 → IDLE.
- Total bytes: 3·Σ size(o) (16128 for 64×64), plus 9 headers if enabled.
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-dump aborts without `done_out`; next start restarts at octave 0 level 0 addr 0.

## Timing
- `start_in` high cycle 0 → `busy_out` high cycle 1; first `read_en_out` cycle 1 (no header) or cycle after header handshake.
- Bank read latency fixed 2: data for `read_en_out` in cycle N valid on `bank_pixel_in` in N+2; `tx_valid_out` high from N+3.
- Handshake edge N+3 earliest; next `read_en_out` in N+4 → min 4 cycles/pixel with `tx_ready_in` tied high.
- `tx_ready_in` low: hold `tx_valid_out`, `tx_data_out`, addr; no further reads issued.
- `read_en_out` zero outside ISSUE; never more than one bit set.
- `tx_valid_out` never high in IDLE, ISSUE, WAIT1, WAIT2, DONE.

## Configuration
- `PYRAMID_DUMP_HEADER_EN` defined: HEADER state compiled in; one header byte precedes each image.
- Undefined: HEADER absent, transitions go directly to ISSUE; stream is raw pixels only.

## Structure
- Shared package `pyramid_pkg`: `NUM_OCTAVES`=3, `NUM_LEVELS`=3, `HDR_MAGIC`=4'hA, dump state enum, bank-index function (octave×3+level).
- One sub-module `pyramid_scan_counter`: octave/level/addr counters, size compare, `last_pixel`/`last_image` flags, advance input.

## Test plan
- 64×64, ready tied high, header off, banks preloaded with addr[7:0]^bank → 16128 bytes in order, bank 0 bytes 0..4095, consecutive `read_en_out` 4 cycles apart, single `done_out`.
- Header on → 16137 bytes; header values 0xA0,0xA1,0xA2,0xA4,…,0xAA at image boundaries.
- `tx_ready_in` random 30% duty → identical byte sequence; valid/data never change while waiting.
- `start_in` pulsed mid-dump and on final handshake cycle → ignored; exactly one `done_out`.
- `rst_in` at byte 2000 → all outputs 0 next cycle, no `done_out`; new start restarts at addr 0 bank 0.
- 16×8 image → per-octave sizes 128/32/8, total 504 bytes; addr wraps correctly at each boundary.
